// File: rtl/spi_bridge_pkg.sv
// Shared types and constants for the SPI-to-I2C bridge front end.
package spi_bridge_pkg;
  localparam int DATA_W_DEF = 8;
  localparam logic [DATA_W_DEF-1:0] IDLE_MISO = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_e;
endpackage

// File: rtl/spi_frame_ctrl_if.sv
// Byte-level handshake between the SPI front end (master) and the I2C side (slave).
interface spi_frame_ctrl_if
  import spi_bridge_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic [DATA_W-1:0] rx_data;
  logic              rx_first;
  logic              rx_valid;
  logic              rx_ready;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output rx_data, rx_first, rx_valid, tx_ready,
    input  rx_ready, tx_data, tx_valid
  );
  modport slave (
    input  rx_data, rx_first, rx_valid, tx_ready,
    output rx_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/spi_rx_fifo.sv
// Small synchronous FIFO, 0-cycle read of head; a push into a full FIFO is dropped
// unless a pop happens in the same cycle.
module spi_rx_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld_i,
  input  logic [W-1:0] in_dat_i,
  output logic         out_vld_o,
  output logic [W-1:0] out_dat_o,
  input  logic         out_rdy_i,
  output logic         full_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push, pop;

  assign full_o    = (cnt_q == CNT_FULL);
  assign out_vld_o = (cnt_q != '0);
  assign out_dat_o = mem_q[rd_ptr_q];
  assign pop       = out_vld_o & out_rdy_i;
  assign push      = in_vld_i & (~full_o | pop);

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CNT_ONE;
    else if (pop && !push) cnt_d = cnt_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_dat_i;
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/spi_frame_ctrl.sv
// SPI mode-0 slave front end: pins synchronised, actions SYNC_STAGES+1 clk after a pin edge.
// Completed bytes queue in a small FIFO; when it is full the byte is dropped and overrun latches.
module spi_frame_ctrl
  import spi_bridge_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int RX_DEPTH    = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic spi_sclk,
  input  logic spi_ss_n,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic spi_miso_oe,
  output logic frame_active,
  output logic frame_end,
  output logic overrun,
  output logic short_frame,
  input  logic clr_err,
  spi_frame_ctrl_if.master bus
);
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q, flush_q;
  logic sclk_prev_q, ss_prev_q, ss_armed_q;
  logic sclk_s, ss_s, mosi_s;
  logic sclk_rise, sclk_fall, ss_fall, ss_rise;

  // ss_armed_q blocks a frame start until SS has been seen high after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      flush_q     <= '0;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b1;
      ss_armed_q  <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], spi_ss_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      flush_q     <= {flush_q[SYNC_STAGES-2:0], 1'b1};
      sclk_prev_q <= sclk_s;
      ss_prev_q   <= ss_s;
      if (flush_q[SYNC_STAGES-1] && ss_s) ss_armed_q <= 1'b1;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign ss_fall   = ss_armed_q & ss_prev_q & ~ss_s;
  assign ss_rise   = ss_s & ~ss_prev_q;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d, tx_next;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic first_q, first_d, miso_q, miso_d, oe_q, oe_d, active_q, active_d;
  logic fend_q, fend_d, ovr_q, ovr_d, short_q, short_d;
  logic tx_take, push_vld, short_set, ovr_set, fifo_full, fifo_pop;
  logic [DATA_W:0] push_dat, fifo_dat;

  assign tx_next  = bus.tx_valid ? bus.tx_data : {DATA_W{IDLE_MISO[0]}};
  assign push_dat = {first_q, rx_shift_q[DATA_W-2:0], mosi_s};
  assign fifo_pop = bus.rx_valid & bus.rx_ready;
  assign ovr_set  = push_vld & fifo_full & ~fifo_pop;

  always_comb begin
    state_d    = state_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    bit_cnt_d  = bit_cnt_q;
    first_d    = first_q;
    miso_d     = miso_q;
    oe_d       = oe_q;
    active_d   = active_q;
    fend_d     = 1'b0;
    tx_take    = 1'b0;
    push_vld   = 1'b0;
    short_set  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d  = LOAD;
          active_d = 1'b1;
          first_d  = 1'b1;
        end
      end
      LOAD: begin
        tx_shift_d = tx_next;
        tx_take    = bus.tx_valid;
        miso_d     = tx_next[DATA_W-1];
        oe_d       = 1'b1;
        bit_cnt_d  = '0;
        state_d    = SHIFT;
      end
      SHIFT: begin
        if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
          if (bit_cnt_q == LAST_BIT) begin
            push_vld   = 1'b1;
            first_d    = 1'b0;
            bit_cnt_d  = '0;
            tx_shift_d = tx_next;
            tx_take    = bus.tx_valid;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_ONE;
          end
        end else if (sclk_fall) begin
          // At a byte boundary the reloaded MSB goes out without a shift.
          if (bit_cnt_q != '0) begin
            tx_shift_d = tx_shift_q << 1;
            miso_d     = tx_shift_q[DATA_W-2];
          end else begin
            miso_d = tx_shift_q[DATA_W-1];
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // SS release overrides any SCLK edge seen in the same cycle.
    if (state_q != IDLE && ss_rise) begin
      state_d    = IDLE;
      tx_shift_d = tx_shift_q;
      rx_shift_d = rx_shift_q;
      active_d   = 1'b0;
      oe_d       = 1'b0;
      miso_d     = IDLE_MISO[0];
      fend_d     = 1'b1;
      bit_cnt_d  = '0;
      tx_take    = 1'b0;
      push_vld   = 1'b0;
      short_set  = (state_q == SHIFT) && (bit_cnt_q != '0);
    end
    ovr_d   = ovr_set ? 1'b1 : (clr_err ? 1'b0 : ovr_q);
    short_d = short_set ? 1'b1 : (clr_err ? 1'b0 : short_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      bit_cnt_q  <= '0;
      first_q    <= 1'b0;
      miso_q     <= IDLE_MISO[0];
      oe_q       <= 1'b0;
      active_q   <= 1'b0;
      fend_q     <= 1'b0;
      ovr_q      <= 1'b0;
      short_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      bit_cnt_q  <= bit_cnt_d;
      first_q    <= first_d;
      miso_q     <= miso_d;
      oe_q       <= oe_d;
      active_q   <= active_d;
      fend_q     <= fend_d;
      ovr_q      <= ovr_d;
      short_q    <= short_d;
    end
  end

  spi_rx_fifo #(.W(DATA_W + 1), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_vld_i  (push_vld),
    .in_dat_i  (push_dat),
    .out_vld_o (bus.rx_valid),
    .out_dat_o (fifo_dat),
    .out_rdy_i (bus.rx_ready),
    .full_o    (fifo_full)
  );

  assign bus.rx_data  = fifo_dat[DATA_W-1:0];
  assign bus.rx_first = fifo_dat[DATA_W];
  assign bus.tx_ready = tx_take;
  assign spi_miso     = miso_q;
  assign spi_miso_oe  = oe_q;
  assign frame_active = active_q;
  assign frame_end    = fend_q;
  assign overrun      = ovr_q;
  assign short_frame  = short_q;
endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Directed bench for spi_frame_ctrl: an SPI master model plus a byte-queue model of what the
// consumer must see, checked on every handshake.
module tb_spi_frame_ctrl;
  localparam int HALF  = 8;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n, spi_sclk, spi_ss_n, spi_mosi, clr_err;
  logic spi_miso, spi_miso_oe, frame_active, frame_end, overrun, short_frame;

  spi_frame_ctrl_if #(.DATA_W(8)) bus ();

  spi_frame_ctrl #(.DATA_W(8), .SYNC_STAGES(2), .RX_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .spi_sclk     (spi_sclk),
    .spi_ss_n     (spi_ss_n),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .spi_miso_oe  (spi_miso_oe),
    .frame_active (frame_active),
    .frame_end    (frame_end),
    .overrun      (overrun),
    .short_frame  (short_frame),
    .clr_err      (clr_err),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int n_txr = 0, n_fend = 0, n_oe = 0, n_pop = 0;
  logic [8:0] mq[$];
  logic [7:0] txq[$];
  logic       exp_ovr = 1'b0;
  logic [8:0] exp_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected consumer view: a FIFO of DEPTH bytes that only fills while nobody reads it.
  task automatic model_push(input logic [8:0] e);
    if (!bus.rx_ready && mq.size() >= DEPTH) exp_ovr = 1'b1;
    else mq.push_back(e);
  endtask

  task automatic spi_bits(input logic [7:0] mo, input int nb, input bit first, input bit do_push,
                          input bit chk_miso, input logic [7:0] exp_miso, input string nm);
    logic [7:0] got;
    got = '0;
    for (int i = 0; i < nb; i++) begin
      spi_mosi = mo[7-i];
      wclk(HALF);
      spi_sclk = 1'b1;
      got = {got[6:0], spi_miso};
      if (do_push && i == 7) model_push({first, mo});
      wclk(HALF);
      spi_sclk = 1'b0;
    end
    if (chk_miso) chk(nm, {24'd0, got}, {24'd0, exp_miso});
  endtask

  task automatic spi_byte(input logic [7:0] mo, input bit first, input logic [7:0] exp_miso,
                          input string nm);
    spi_bits(mo, 8, first, 1'b1, 1'b1, exp_miso, nm);
  endtask

  task automatic ss_low();
    spi_ss_n = 1'b0;
    wclk(HALF);
  endtask

  task automatic ss_high();
    wclk(HALF);
    spi_ss_n = 1'b1;
    wclk(2 * HALF);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    wclk(1);
    clr_err = 1'b0;
    wclk(1);
    exp_ovr = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_miso"}, {31'd0, spi_miso}, 32'd1);
    chk({tag, "_oe"}, {31'd0, spi_miso_oe}, 32'd0);
    chk({tag, "_rx_valid"}, {31'd0, bus.rx_valid}, 32'd0);
    chk({tag, "_rx_data"}, {24'd0, bus.rx_data}, 32'd0);
    chk({tag, "_rx_first"}, {31'd0, bus.rx_first}, 32'd0);
    chk({tag, "_tx_ready"}, {31'd0, bus.tx_ready}, 32'd0);
    chk({tag, "_frame_active"}, {31'd0, frame_active}, 32'd0);
    chk({tag, "_frame_end"}, {31'd0, frame_end}, 32'd0);
    chk({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
    chk({tag, "_short_frame"}, {31'd0, short_frame}, 32'd0);
  endtask

  // TX producer: presents the next queued byte, retires it once the DUT has taken it.
  initial begin
    bit took;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    forever begin
      @(negedge clk);
      took = rst_n && bus.tx_valid && bus.tx_ready;
      @(posedge clk);
      #1;
      if (took) bus.tx_valid = 1'b0;
      if (!bus.tx_valid && txq.size() > 0) begin
        bus.tx_data  = txq.pop_front();
        bus.tx_valid = 1'b1;
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.tx_ready) n_txr++;
      if (frame_end) n_fend++;
      if (spi_miso_oe) n_oe++;
      chk("oe_outside_frame", {31'd0, spi_miso_oe & ~frame_active}, 32'd0);
      chk("tx_ready_without_valid", {31'd0, bus.tx_ready & ~bus.tx_valid}, 32'd0);
      if (bus.rx_valid && bus.rx_ready) begin
        n_pop++;
        if (mq.size() == 0) begin
          chk("rx_pop_unexpected", {23'd0, bus.rx_first, bus.rx_data}, 32'h1ff);
        end else begin
          exp_e = mq.pop_front();
          chk("rx_pop", {23'd0, bus.rx_first, bus.rx_data}, {23'd0, exp_e});
        end
      end
    end
  end

  initial begin
    int b_txr, b_fend, b_pop, b_oe;
    rst_n = 1'b0; spi_sclk = 1'b0; spi_ss_n = 1'b1; spi_mosi = 1'b0; clr_err = 1'b0;
    bus.rx_ready = 1'b0;
    wclk(4);
    chk_reset("reset");
    rst_n = 1'b1;
    wclk(6);

    // 1: single byte, one TX byte available
    b_txr = n_txr; b_fend = n_fend; b_pop = n_pop;
    txq.push_back(8'h3C);
    wclk(3);
    ss_low();
    spi_byte(8'hA5, 1'b1, 8'h3C, "t1_miso");
    ss_high();
    chk("t1_rx_valid", {31'd0, bus.rx_valid}, 32'd1);
    chk("t1_rx_data", {24'd0, bus.rx_data}, 32'hA5);
    chk("t1_rx_first", {31'd0, bus.rx_first}, 32'd1);
    chk("t1_tx_ready_pulses", n_txr - b_txr, 32'd1);
    chk("t1_frame_end_pulses", n_fend - b_fend, 32'd1);
    bus.rx_ready = 1'b1;
    wclk(4);
    chk("t1_pops", n_pop - b_pop, 32'd1);
    chk("t1_drained", {31'd0, bus.rx_valid}, 32'd0);

    // 2: three bytes, no TX data, consumer always ready
    b_txr = n_txr; b_fend = n_fend; b_pop = n_pop;
    ss_low();
    spi_byte(8'h11, 1'b1, 8'hFF, "t2_miso0");
    spi_byte(8'h22, 1'b0, 8'hFF, "t2_miso1");
    spi_byte(8'h33, 1'b0, 8'hFF, "t2_miso2");
    ss_high();
    chk("t2_pops", n_pop - b_pop, 32'd3);
    chk("t2_model_empty", mq.size(), 32'd0);
    chk("t2_tx_ready_pulses", n_txr - b_txr, 32'd0);
    chk("t2_frame_end_pulses", n_fend - b_fend, 32'd1);
    chk("t2_overrun", {31'd0, overrun}, {31'd0, exp_ovr});

    // 3: consumer stalled, third byte overruns
    bus.rx_ready = 1'b0;
    b_pop = n_pop;
    ss_low();
    spi_byte(8'h11, 1'b1, 8'hFF, "t3_miso0");
    spi_byte(8'h22, 1'b0, 8'hFF, "t3_miso1");
    spi_byte(8'h33, 1'b0, 8'hFF, "t3_miso2");
    ss_high();
    chk("t3_overrun_model", {31'd0, overrun}, {31'd0, exp_ovr});
    chk("t3_overrun", {31'd0, overrun}, 32'd1);
    chk("t3_head", {23'd0, bus.rx_first, bus.rx_data}, 32'h111);
    pulse_clr();
    chk("t3_overrun_clr", {31'd0, overrun}, 32'd0);
    bus.rx_ready = 1'b1;
    wclk(4);
    chk("t3_pops", n_pop - b_pop, 32'd2);
    chk("t3_model_empty", mq.size(), 32'd0);

    // 4: short frame, then a clean one
    b_fend = n_fend; b_pop = n_pop;
    ss_low();
    spi_bits(8'hF0, 5, 1'b0, 1'b0, 1'b0, 8'h00, "t4_partial");
    ss_high();
    chk("t4_short_frame", {31'd0, short_frame}, 32'd1);
    chk("t4_frame_end_pulses", n_fend - b_fend, 32'd1);
    chk("t4_no_pop", n_pop - b_pop, 32'd0);
    pulse_clr();
    chk("t4_short_clr", {31'd0, short_frame}, 32'd0);
    ss_low();
    spi_byte(8'h5A, 1'b1, 8'hFF, "t4_miso");
    ss_high();
    chk("t4_pops", n_pop - b_pop, 32'd1);
    chk("t4_model_empty", mq.size(), 32'd0);
    chk("t4_short_stays", {31'd0, short_frame}, 32'd0);

    // 5: reset in the middle of a byte, SS held low through reset
    b_pop = n_pop;
    ss_low();
    spi_bits(8'hC3, 4, 1'b0, 1'b0, 1'b0, 8'h00, "t5_partial");
    rst_n = 1'b0;
    wclk(3);
    chk_reset("t5_reset");
    rst_n = 1'b1;
    wclk(10);
    chk("t5_no_restart", {31'd0, frame_active}, 32'd0);
    spi_ss_n = 1'b1;
    wclk(2 * HALF);
    ss_low();
    chk("t5_active", {31'd0, frame_active}, 32'd1);
    spi_byte(8'hC3, 1'b1, 8'hFF, "t5_miso");
    ss_high();
    chk("t5_pops", n_pop - b_pop, 32'd1);
    chk("t5_model_empty", mq.size(), 32'd0);
    chk("t5_short", {31'd0, short_frame}, 32'd0);

    // 6: SCLK activity with SS high is ignored
    b_txr = n_txr; b_pop = n_pop; b_oe = n_oe;
    txq.push_back(8'h99);
    wclk(4);
    for (int i = 0; i < 16; i++) begin
      spi_mosi = i[0];
      wclk(HALF / 2);
      spi_sclk = 1'b1;
      wclk(HALF / 2);
      spi_sclk = 1'b0;
    end
    wclk(6);
    chk("t6_no_pop", n_pop - b_pop, 32'd0);
    chk("t6_no_tx_ready", n_txr - b_txr, 32'd0);
    chk("t6_no_oe", n_oe - b_oe, 32'd0);
    chk("t6_inactive", {31'd0, frame_active}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
